// File: rtl/apb_master_sequencer.sv
// APB master sequencer: arbitrates data/config request channels, runs one
// SETUP/ACCESS transfer at a time and returns a per-transfer response.
module apb_master_sequencer #(
   parameter int TOTAL_SLAVE    = 8,
   parameter int SLV_ID_WIDTH   = 7,
   parameter int ADDR_WIDTH     = 7,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    dat_req,
   input  logic                    dat_write,
   input  logic [SLV_ID_WIDTH-1:0] dat_id,
   input  logic [ADDR_WIDTH-1:0]   dat_addr,
   input  logic [DATA_WIDTH-1:0]   dat_wdata,
   output logic                    dat_ack,
   input  logic                    cfg_req,
   input  logic [SLV_ID_WIDTH-1:0] cfg_id,
   input  logic [ADDR_WIDTH-1:0]   cfg_addr,
   input  logic [DATA_WIDTH-1:0]   cfg_wdata,
   output logic                    cfg_ack,
   output logic                    rsp_valid,
   output logic                    rsp_src,
   output logic                    rsp_err,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    busy,
   output logic [TOTAL_SLAVE-1:0]  psel,
   output logic                    penable,
   output logic                    pwrite,
   output logic [ADDR_WIDTH-1:0]   paddr,
   output logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH-1:0]   prdata,
   input  logic                    pready,
   input  logic                    pslverr
);

   // state  | meaning
   // IDLE   | waiting for a request; grants and captures on the clock edge
   // SETUP  | APB setup phase: psel high, penable low (one cycle)
   // ACCESS | APB access phase: psel and penable high until pready or timeout
   // ERR    | captured id out of range; one cycle, no APB activity

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_ERR    = 2'd3
   } state_t;

   localparam int                     CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]            SLV_LIMIT = 32'(TOTAL_SLAVE);
   localparam logic [TOTAL_SLAVE-1:0] SEL_ONE   = TOTAL_SLAVE'(1);

   state_t                  state;
   state_t                  state_nxt;

   logic                    last_grant;
   logic                    grant_any;
   logic                    grant_cfg;
   logic [SLV_ID_WIDTH-1:0] sel_id;
   logic                    id_ok;

   logic [SLV_ID_WIDTH-1:0] id_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    write_q;
   logic                    src_q;

   logic [CNT_W-1:0]        wait_cnt;
   logic                    access_done;
   logic                    access_tmo;
   logic                    capture;

   // round-robin: on a tie, the channel that did not win last time gets it
   always_comb begin
      grant_any = dat_req | cfg_req;
      grant_cfg = cfg_req & (~dat_req | ~last_grant);
      sel_id    = grant_cfg ? cfg_id : dat_id;
      id_ok     = (32'(sel_id) < SLV_LIMIT);
      capture   = (state == ST_IDLE) && grant_any;
   end

   always_comb begin
      access_done = (state == ST_ACCESS) && pready;
      access_tmo  = (state == ST_ACCESS) && !pready && (wait_cnt == CNT_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (grant_any) state_nxt = id_ok ? ST_SETUP : ST_ERR;
         end
         ST_SETUP:  state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            if (access_done || access_tmo) state_nxt = ST_IDLE;
         end
         ST_ERR:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
         id_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         src_q      <= 1'b0;
      end else if (capture) begin
         last_grant <= grant_cfg;
         id_q       <= sel_id;
         addr_q     <= grant_cfg ? cfg_addr : dat_addr;
         wdata_q    <= grant_cfg ? cfg_wdata : dat_wdata;
         write_q    <= grant_cfg | dat_write;
         src_q      <= grant_cfg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dat_ack <= 1'b0;
         cfg_ack <= 1'b0;
      end else begin
         dat_ack <= capture & ~grant_cfg;
         cfg_ack <= capture & grant_cfg;
      end
   end

   // wait-state counter runs only while stalled in ACCESS; any exit clears it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if ((state == ST_ACCESS) && !pready && (wait_cnt != CNT_LAST)) begin
         wait_cnt <= wait_cnt + 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_src   <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= access_done | access_tmo | (state == ST_ERR);
         rsp_src   <= (access_done | access_tmo | (state == ST_ERR)) ? src_q : 1'b0;
         rsp_err   <= access_done ? pslverr : (access_tmo | (state == ST_ERR));
         rsp_rdata <= (access_done && !write_q) ? prdata : '0;
      end
   end

   always_comb begin
      busy    = (state == ST_SETUP) || (state == ST_ACCESS);
      psel    = busy ? (SEL_ONE << id_q) : '0;
      penable = (state == ST_ACCESS);
      pwrite  = write_q;
      paddr   = addr_q;
      pwdata  = wdata_q;
   end

endmodule

// File: tb/tb_apb_master_sequencer.sv
// Randomized bench for apb_master_sequencer: a transaction-level model predicts
// grant order, APB phase timing and the response of every transfer.
module tb_apb_master_sequencer;

   localparam int TS  = 8;
   localparam int IDW = 7;
   localparam int AW  = 7;
   localparam int DW  = 32;
   localparam int TO  = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           dat_req, dat_write, cfg_req;
   logic [IDW-1:0] dat_id, cfg_id;
   logic [AW-1:0]  dat_addr, cfg_addr;
   logic [DW-1:0]  dat_wdata, cfg_wdata;
   logic           dat_ack, cfg_ack;
   logic           rsp_valid, rsp_src, rsp_err;
   logic [DW-1:0]  rsp_rdata;
   logic           busy;
   logic [TS-1:0]  psel;
   logic           penable, pwrite;
   logic [AW-1:0]  paddr;
   logic [DW-1:0]  pwdata, prdata;
   logic           pready, pslverr;

   int n_cmp = 0;
   int n_err = 0;
   bit model_last;   // 1 = config channel won the previous grant

   apb_master_sequencer #(
      .TOTAL_SLAVE(TS), .SLV_ID_WIDTH(IDW), .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .dat_req(dat_req), .dat_write(dat_write), .dat_id(dat_id),
      .dat_addr(dat_addr), .dat_wdata(dat_wdata), .dat_ack(dat_ack),
      .cfg_req(cfg_req), .cfg_id(cfg_id), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack),
      .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_err(rsp_err),
      .rsp_rdata(rsp_rdata), .busy(busy),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One transfer from request to response; called and returns at a negedge.
   // waits >= TO means pready never rises (timeout).
   task automatic run_xfer(input bit dq, input bit cq, input bit dw,
                           input logic [IDW-1:0] did, input logic [IDW-1:0] cid,
                           input logic [AW-1:0] dad, input logic [AW-1:0] cad,
                           input logic [DW-1:0] dwd, input logic [DW-1:0] cwd,
                           input int waits, input bit serr, input logic [DW-1:0] prd);
      bit             gcfg, wr, ok, tmo, exp_err;
      logic [IDW-1:0] id;
      logic [AW-1:0]  ad;
      logic [DW-1:0]  wd, exp_rdata;
      logic [TS-1:0]  exp_psel;
      int             n;

      gcfg       = cq && (!dq || !model_last);
      model_last = gcfg;
      id  = gcfg ? cid : did;
      ad  = gcfg ? cad : dad;
      wd  = gcfg ? cwd : dwd;
      wr  = gcfg ? 1'b1 : dw;
      ok  = (int'(id) < TS);
      tmo = (waits >= TO);
      n   = tmo ? TO : waits + 1;
      exp_psel  = '0;
      if (ok) exp_psel[id] = 1'b1;
      exp_err   = !ok || tmo || serr;
      exp_rdata = (ok && !tmo && !wr) ? prd : '0;

      dat_req = dq; dat_write = dw; dat_id = did; dat_addr = dad; dat_wdata = dwd;
      cfg_req = cq; cfg_id = cid; cfg_addr = cad; cfg_wdata = cwd;
      pready = 1'b0;

      @(negedge clk);
      check_val("dat_ack", 32'(dat_ack), 32'(!gcfg));
      check_val("cfg_ack", 32'(cfg_ack), 32'(gcfg));
      dat_req = 1'b0;
      cfg_req = 1'b0;

      if (!ok) begin
         check_val("err_psel", 32'(psel), 32'(0));
         check_val("err_busy", 32'(busy), 32'(0));
         @(negedge clk);
         check_val("err_rsp_valid", 32'(rsp_valid), 32'(1));
         check_val("err_rsp_err", 32'(rsp_err), 32'(1));
         check_val("err_rsp_src", 32'(rsp_src), 32'(gcfg));
         check_val("err_rsp_rdata", rsp_rdata, 32'(0));
         return;
      end

      check_val("setup_busy", 32'(busy), 32'(1));
      check_val("setup_psel", 32'(psel), 32'(exp_psel));
      check_val("setup_penable", 32'(penable), 32'(0));
      check_val("setup_pwrite", 32'(pwrite), 32'(wr));
      check_val("setup_paddr", 32'(paddr), 32'(ad));
      check_val("setup_pwdata", pwdata, wd);

      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check_val("acc_penable", 32'(penable), 32'(1));
         check_val("acc_psel", 32'(psel), 32'(exp_psel));
         check_val("acc_rsp_valid", 32'(rsp_valid), 32'(0));
         if (k == 0) check_val("ack_pulse", 32'({dat_ack, cfg_ack}), 32'(0));
         if (k == n - 1) begin
            check_val("acc_paddr", 32'(paddr), 32'(ad));
            check_val("acc_pwdata", pwdata, wd);
         end
         if (k == waits) begin
            pready = 1'b1; pslverr = serr; prdata = prd;
         end else begin
            pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
         end
      end

      @(negedge clk);
      pready = 1'b0;
      check_val("end_psel", 32'(psel), 32'(0));
      check_val("end_penable", 32'(penable), 32'(0));
      check_val("rsp_valid", 32'(rsp_valid), 32'(1));
      check_val("rsp_src", 32'(rsp_src), 32'(gcfg));
      check_val("rsp_err", 32'(rsp_err), 32'(exp_err));
      check_val("rsp_rdata", rsp_rdata, exp_rdata);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      dat_req = 0; dat_write = 0; dat_id = '0; dat_addr = '0; dat_wdata = '0;
      cfg_req = 0; cfg_id = '0; cfg_addr = '0; cfg_wdata = '0;
      prdata = '0; pready = 0; pslverr = 0;
      model_last = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_psel", 32'(psel), 32'(0));
      check_val("rst_ctrl", 32'({penable, pwrite, busy, dat_ack, cfg_ack, rsp_valid, rsp_src, rsp_err}), 32'(0));
      check_val("rst_rdata", rsp_rdata, 32'(0));
      check_val("rst_paddr", 32'(paddr), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      // directed cases
      run_xfer(1, 0, 1, 7'd3, 7'd0, 7'h33, 7'h00, 32'hDEADBEEF, 32'h0, 0, 0, 32'hA5A5A5A5);
      run_xfer(1, 0, 0, 7'd0, 7'd0, 7'h10, 7'h00, 32'h0, 32'h0, 2, 0, 32'h12345678);
      run_xfer(1, 0, 0, 7'd5, 7'd0, 7'h21, 7'h00, 32'h0, 32'h0, 40, 0, 32'h55AA55AA);
      run_xfer(1, 0, 1, 7'd7, 7'd0, 7'h7F, 7'h00, 32'hCAFEF00D, 32'h0, 1, 1, 32'h0);
      run_xfer(0, 1, 0, 7'd0, 7'd9, 7'h00, 7'h12, 32'h0, 32'h11112222, 0, 0, 32'h0);
      for (int i = 0; i < 4; i++)
         run_xfer(1, 1, 0, 7'd1, 7'd2, 7'h40 + 7'(i), 7'h50 + 7'(i),
                  32'h1000 + 32'(i), 32'h2000 + 32'(i), i % 2, 0, 32'h3000 + 32'(i));

      // reset during ACCESS drops the transfer
      dat_req = 1; dat_write = 0; dat_id = 7'd4; dat_addr = 7'h2A; cfg_req = 0;
      @(negedge clk);
      dat_req = 0;
      @(negedge clk);
      check_val("pre_rst_penable", 32'(penable), 32'(1));
      #2 rst = 1'b1;
      #1;
      check_val("mid_rst_psel", 32'(psel), 32'(0));
      check_val("mid_rst_penable", 32'(penable), 32'(0));
      check_val("mid_rst_busy", 32'(busy), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      model_last = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("post_rst_rsp", 32'(rsp_valid), 32'(0));
      end
      run_xfer(1, 1, 0, 7'd6, 7'd2, 7'h0C, 7'h0D, 32'h0, 32'h77, 1, 0, 32'hFEEDFACE);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         bit dq, cq;
         int w;
         dq = 1'($urandom);
         cq = dq ? 1'($urandom) : 1'b1;
         w  = ($urandom_range(0, 7) == 0) ? TO + 3 : int'($urandom_range(0, 3));
         run_xfer(dq, cq, 1'($urandom),
                  7'($urandom_range(0, 9)), 7'($urandom_range(0, 9)),
                  7'($urandom), 7'($urandom), $urandom, $urandom,
                  w, ($urandom_range(0, 5) == 0), $urandom);
      end

      @(negedge clk);
      check_val("final_rsp_idle", 32'(rsp_valid), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/apb_master_sequencer.md
Name: apb_master_sequencer

Overview:
Sequences APB transfers for the bridge. It arbitrates between the data channel (read/write requests from the data controller) and the config channel (write-only config requests). It then drives a standard two-phase APB master interface (SETUP/ACCESS) with a one-hot slave select. It returns a per-transfer response carrying read data, an error flag and the source channel, and aborts a transfer on wait-state timeout.

Parameters:
TOTAL_SLAVE, 8, number of APB slaves; width of psel
SLV_ID_WIDTH, 7, width of slave id fields
ADDR_WIDTH, 7, width of paddr and request address fields
DATA_WIDTH, 32, width of pwdata/prdata and request data
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready low before abort (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
dat_req  in  1  data channel request; held until dat_ack
dat_write  in  1  1=write, 0=read
dat_id  in  SLV_ID_WIDTH  target slave index
dat_addr  in  ADDR_WIDTH  target register address
dat_wdata  in  DATA_WIDTH  write data
dat_ack  out  1  one-cycle pulse: data request captured
cfg_req  in  1  config channel request (always write); held until cfg_ack
cfg_id  in  SLV_ID_WIDTH  target slave index
cfg_addr  in  ADDR_WIDTH  config register address
cfg_wdata  in  DATA_WIDTH  config write data
cfg_ack  out  1  one-cycle pulse: config request captured
rsp_valid  out  1  one-cycle pulse: transfer complete
rsp_src  out  1  0=data channel, 1=config channel
rsp_err  out  1  pslverr, timeout or bad id
rsp_rdata  out  DATA_WIDTH  prdata for reads, 0 otherwise
busy  out  1  high in SETUP/ACCESS
psel  out  TOTAL_SLAVE  one-hot APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
prdata  in  DATA_WIDTH  APB read data (muxed)
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset: all outputs 0; FSM=IDLE; timeout counter=0; last_grant=1 (config), so data wins the first tie. Reset mid-transfer drops it: no rsp_valid, psel/penable low immediately.
- FSM states: IDLE, SETUP, ACCESS, ERR.
- IDLE: if any req is high, grant and capture id/addr/wdata/write/src at the clock edge. cfg writes force pwrite=1.
  - If the captured id < TOTAL_SLAVE: go to SETUP.
  - Else go to ERR; no APB activity.
- Arbitration: one req -> grant it. Both -> round-robin: grant the channel opposite last_grant. last_grant updates on every grant.
- Acks: dat_ack/cfg_ack pulse for exactly one cycle, in the cycle after capture (first SETUP or ERR cycle). A requester sampling ack high may drop or change req.
- SETUP (1 cycle): psel[id]=1, penable=0, paddr/pwdata/pwrite valid. Next state ACCESS.
- ACCESS: psel held, penable=1, all address/data stable.
  - pready=1: sample prdata/pslverr, deassert psel/penable, go to IDLE. Next cycle: rsp_valid=1, rsp_err=pslverr, rsp_rdata=prdata if read else 0.
  - pready=0: counter increments. If the counter reaches TIMEOUT_CYCLES-1 with pready still low: deassert psel/penable, go to IDLE. Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0. Counter clears on leaving ACCESS.
- ERR (1 cycle): go to IDLE. Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Latency (zero wait states): req sampled high at edge 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> rsp_valid cycle 3.
- Pacing: there is always one IDLE cycle between transfers, so back-to-back requests start every 3 cycles minimum.
- rsp_src/rsp_err/rsp_rdata are valid only while rsp_valid=1 and hold 0 otherwise.
- busy = (state==SETUP || state==ACCESS).
- Requests arriving while not IDLE are ignored until IDLE; no queueing.

Test Plan:
- Single data write: dat_req, id=3, addr=0x33, wdata=0xDEADBEEF, pready=1 -> psel=0x08; penable high 1 cycle; pwrite=1; rsp_valid cycle 3 with err=0, src=0, rdata=0.
- Data read with 2 wait states: id=0, prdata=0x12345678 at pready -> ACCESS lasts 3 cycles; rsp_rdata=0x12345678; rsp_err=0.
- Simultaneous dat_req and cfg_req held high for 4 transfers -> grant order data, cfg, data, cfg; each ack pulses once; rsp_src alternates 0,1,0,1.
- Timeout: pready stuck 0, TIMEOUT_CYCLES=16 -> psel drops after 16 ACCESS cycles; rsp_err=1, rdata=0. Also pslverr=1 with pready=1 -> rsp_err=1.
- Bad id: cfg_id=9 with TOTAL_SLAVE=8 -> psel stays 0; cfg_ack pulses; rsp_valid with err=1, src=1 two cycles after capture.
- Reset asserted during ACCESS -> psel/penable/busy 0 immediately; no rsp_valid; a new request after release completes normally.
